// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if: decoded key event bus from the PS/2 receiver to the matrix stage
interface ps2_scancode_rx_if;
  logic [10:0] ps2_key;
  logic key_stb;
  logic rx_err;
  modport master (output ps2_key, key_stb, rx_err);
  modport slave (input ps2_key, key_stb, rx_err);
endinterface

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: filters raw PS/2 pins, deserialises frames and folds E0/F0/E1 prefixes into key events
module ps2_scancode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT = 50000
) (
  input logic clk_sys,
  input logic reset_n,
  input logic ps2_clk,
  input logic ps2_data,
  ps2_scancode_rx_if.master key_if
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_nxt;
  logic [1:0] clk_sync, dat_sync;
  logic clk_f, flip, fall, bit_in;
  logic [7:0] flt_cnt;
  logic [TW-1:0] tmr;
  logic timeout, start_err, frame_ok, frame_bad;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, byte_q;
  logic par, byte_vld;
  logic ext, brk, is_status;
  logic [2:0] skip;
  logic [10:0] key;
  logic stb, err;
  assign key_if.ps2_key = key;
  assign key_if.key_stb = stb;
  assign key_if.rx_err = err;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  // filtered clk only moves after FILTER_LEN consecutive disagreeing samples
  assign flip = (clk_sync[1] != clk_f) && (flt_cnt == 8'(FILTER_LEN - 1));
  assign fall = flip && clk_f;
  assign bit_in = dat_sync[1];
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      clk_f <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_f <= flip ? ~clk_f : clk_f;
      flt_cnt <= (clk_sync[1] == clk_f || flip) ? '0 : flt_cnt + 8'd1;
    end
  // an edge in the same cycle as expiry wins, so timeout is masked by fall
  assign timeout = (state != IDLE) && !fall && (tmr == TW'(TIMEOUT - 1));
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) tmr <= '0;
    else tmr <= (fall || state == IDLE || timeout) ? '0 : tmr + TW'(1);
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (timeout) state_nxt = IDLE;
    else if (fall)
      case (state)
        IDLE: state_nxt = bit_in ? IDLE : DATA;
        DATA: state_nxt = (bit_cnt == 3'd7) ? PARITY : DATA;
        PARITY: state_nxt = STOP;
        default: state_nxt = IDLE;
      endcase
  end
  always_comb begin
    start_err = fall && state == IDLE && bit_in;
    frame_ok = fall && state == STOP && bit_in && (^{shreg, par});
    frame_bad = fall && state == STOP && !(bit_in && (^{shreg, par}));
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      byte_vld <= 1'b0;
      byte_q <= '0;
      err <= 1'b0;
    end else begin
      bit_cnt <= (fall && state == IDLE) ? '0 : (fall && state == DATA) ? bit_cnt + 3'd1 : bit_cnt;
      shreg <= (fall && state == DATA) ? {bit_in, shreg[7:1]} : shreg;
      par <= (fall && state == PARITY) ? bit_in : par;
      byte_vld <= frame_ok;
      byte_q <= frame_ok ? shreg : byte_q;
      err <= start_err || frame_bad || timeout;
    end
  assign is_status = byte_q inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  // E1 starts the pause sequence; its remaining seven bytes are swallowed
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      key <= '0;
      stb <= 1'b0;
      ext <= 1'b0;
      brk <= 1'b0;
      skip <= '0;
    end else begin
      stb <= 1'b0;
      if (frame_bad || timeout) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_vld) begin
        if (skip != 3'd0) skip <= skip - 3'd1;
        else if (byte_q == 8'hE1) skip <= 3'd7;
        else if (byte_q == 8'hE0) ext <= 1'b1;
        else if (byte_q == 8'hF0) brk <= 1'b1;
        else if (!(is_status && !ext && !brk)) begin
          key <= {~key[10], ~brk, ext, byte_q};
          stb <= 1'b1;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: table-driven frames with a key-event scoreboard plus timeout, glitch and reset sequences
module tb_ps2_scancode_rx;
  localparam int FL = 4;
  localparam int TO = 200;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  ps2_scancode_rx_if key_if();
  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .key_if(key_if)
  );
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0] b;
    bit bad_par;
    bit bad_stop;
    bit exp_stb;
    bit exp_err;
    bit exp_pressed;
    bit exp_ext;
  } vec_t;
  vec_t vecs[$];
  int checks = 0;
  int fails = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  logic [10:0] exp_q[$];
  logic [10:0] e_key;
  logic exp_tog = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_sys)
    if (reset_n) begin
      if (key_if.key_stb) begin
        stb_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_stb: got key %0h expected no strobe", key_if.ps2_key);
        end else begin
          e_key = exp_q.pop_front();
          check("key", 32'(key_if.ps2_key), 32'(e_key));
        end
      end
      if (key_if.rx_err) err_cnt++;
    end

  task automatic add(input logic [7:0] b, input bit bp, input bit bs, input bit es, input bit ee,
                     input bit ep, input bit ex);
    vec_t v;
    v.b = b; v.bad_par = bp; v.bad_stop = bs;
    v.exp_stb = es; v.exp_err = ee; v.exp_pressed = ep; v.exp_ext = ex;
    vecs.push_back(v);
  endtask

  task automatic send_bits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = frame[i];
      repeat (5) @(posedge clk_sys);
      ps2_clk = 1'b0;
      repeat (10) @(posedge clk_sys);
      ps2_clk = 1'b1;
      repeat (10) @(posedge clk_sys);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bp, input bit bs, input int n);
    send_bits({~bs, (~^b) ^ bp, b, 1'b0}, n);
  endtask

  task automatic apply(input vec_t v, input string name);
    int s0, e0;
    s0 = stb_cnt;
    e0 = err_cnt;
    if (v.exp_stb) begin
      exp_tog = ~exp_tog;
      exp_q.push_back({exp_tog, v.exp_pressed, v.exp_ext, v.b});
    end
    send_byte(v.b, v.bad_par, v.bad_stop, 11);
    repeat (30) @(posedge clk_sys);
    check({name, "_stb"}, 32'(stb_cnt - s0), 32'(v.exp_stb));
    check({name, "_err"}, 32'(err_cnt - e0), 32'(v.exp_err));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0;
    vec_t v;
    add(8'h1C, 0, 0, 1, 0, 1, 0);
    add(8'hE0, 0, 0, 0, 0, 0, 0);
    add(8'hF0, 0, 0, 0, 0, 0, 0);
    add(8'h75, 0, 0, 1, 0, 0, 1);
    add(8'h29, 1, 0, 0, 1, 0, 0);
    add(8'h29, 0, 0, 1, 0, 1, 0);
    add(8'hE1, 0, 0, 0, 0, 0, 0);
    add(8'h14, 0, 0, 0, 0, 0, 0);
    add(8'h77, 0, 0, 0, 0, 0, 0);
    add(8'hE1, 0, 0, 0, 0, 0, 0);
    add(8'hF0, 0, 0, 0, 0, 0, 0);
    add(8'h14, 0, 0, 0, 0, 0, 0);
    add(8'hF0, 0, 0, 0, 0, 0, 0);
    add(8'h77, 0, 0, 0, 0, 0, 0);
    add(8'h16, 0, 0, 1, 0, 1, 0);
    add(8'hAA, 0, 0, 0, 0, 0, 0);
    add(8'hFA, 0, 0, 0, 0, 0, 0);
    add(8'hE0, 0, 0, 0, 0, 0, 0);
    add(8'hAA, 0, 0, 1, 0, 1, 1);
    add(8'hF0, 0, 0, 0, 0, 0, 0);
    add(8'h33, 0, 1, 0, 1, 0, 0);
    add(8'h33, 0, 0, 1, 0, 1, 0);
    add(8'hE0, 0, 0, 0, 0, 0, 0);
    add(8'h6B, 1, 0, 0, 1, 0, 0);
    add(8'h6B, 0, 0, 1, 0, 1, 0);

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("reset_key", 32'(key_if.ps2_key), 32'h0);
    check("reset_stb", 32'(key_if.key_stb), 32'h0);
    check("reset_err", 32'(key_if.rx_err), 32'h0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk_sys);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d_%02h", i, vecs[i].b));
      if (i == 0) check("first_key", 32'(key_if.ps2_key), 32'h61C);
    end

    s0 = stb_cnt;
    e0 = err_cnt;
    send_byte(8'h5A, 0, 0, 4);
    repeat (TO + 30) @(posedge clk_sys);
    check("timeout_err", 32'(err_cnt - e0), 32'd1);
    check("timeout_stb", 32'(stb_cnt - s0), 32'd0);
    add(8'h5A, 0, 0, 1, 0, 1, 0);
    apply(vecs[vecs.size() - 1], "after_timeout");

    s0 = stb_cnt;
    e0 = err_cnt;
    @(posedge clk_sys);
    ps2_clk = 1'b0;
    repeat (2) @(posedge clk_sys);
    ps2_clk = 1'b1;
    repeat (20) @(posedge clk_sys);
    check("glitch_err", 32'(err_cnt - e0), 32'd0);
    check("glitch_stb", 32'(stb_cnt - s0), 32'd0);

    send_byte(8'h4D, 0, 0, 5);
    ps2_clk = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset_key", 32'(key_if.ps2_key), 32'h0);
    check("midreset_stb", 32'(key_if.key_stb), 32'h0);
    check("midreset_err", 32'(key_if.rx_err), 32'h0);
    exp_q.delete();
    exp_tog = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(posedge clk_sys);
    reset_n = 1'b1;
    repeat (10) @(posedge clk_sys);
    v.b = 8'h1C; v.bad_par = 0; v.bad_stop = 0;
    v.exp_stb = 1; v.exp_err = 0; v.exp_pressed = 1; v.exp_ext = 0;
    apply(v, "after_reset");
    check("after_reset_key", 32'(key_if.ps2_key), 32'h61C);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
